// File: rtl/ahbmtx_pkg.sv
// ----------------------------------------------------------------------------
// ahbmtx_pkg
// Shared definitions for the L1 AHB matrix: HTRANS and HBURST encodings,
// the input-stage FSM state type and a burst-length helper.
// No ports (package).
// ----------------------------------------------------------------------------
package ahbmtx_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HBURST encodings
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Input-stage FSM states
   typedef enum logic {
      ST_PASS = 1'b0,
      ST_HOLD = 1'b1
   } in_stg_state_e;

   // Number of beats remaining after the first one (undefined-length INCR and
   // SINGLE have no tracked remainder).
   function automatic logic [4:0] burst_len_m1(input logic [2:0] hburst);
      logic [4:0] len;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  len = 5'd3;
         HBURST_WRAP8,  HBURST_INCR8:  len = 5'd7;
         HBURST_WRAP16, HBURST_INCR16: len = 5'd15;
         default:                      len = 5'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahbmtx_l1_in_stg_burst_trk.sv
// ----------------------------------------------------------------------------
// ahbmtx_l1_in_stg_burst_trk
// Tracks the remaining beats of the current master burst and the rebase flag
// that marks a burst whose interrupted beat was replayed as NONSEQ/INCR.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   acc          a beat was accepted by the slave bus this cycle
//   acc_trans    original (master) HTRANS of the accepted beat
//   acc_burst    original (master) HBURST of the accepted beat
//   idle_seen    master presented an IDLE beat to this port
//   set_rebase   a SEQ beat is being captured for rebased replay
//   rebase       flag: later SEQ beats of this burst are driven as INCR
// ----------------------------------------------------------------------------
module ahbmtx_l1_in_stg_burst_trk
   import ahbmtx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       acc,
   input  logic [1:0] acc_trans,
   input  logic [2:0] acc_burst,
   input  logic       idle_seen,
   input  logic       set_rebase,
   output logic       rebase
);

   logic [4:0] beat_cnt;
   logic [4:0] beat_cnt_nxt;
   logic       rebase_nxt;

   // Next beat count and rebase flag
   always_comb begin
      beat_cnt_nxt = beat_cnt;
      rebase_nxt   = rebase;
      if (set_rebase) begin
         rebase_nxt = 1'b1;
      end else if (idle_seen) begin
         rebase_nxt = 1'b0;
      end else if (acc) begin
         if (acc_trans == HTRANS_NONSEQ) begin
            beat_cnt_nxt = burst_len_m1(acc_burst);
            rebase_nxt   = 1'b0;
         end else if (acc_trans == HTRANS_SEQ) begin
            // saturate at zero; undefined-length INCR stays at zero
            if (beat_cnt != 5'd0) begin
               beat_cnt_nxt = beat_cnt - 5'd1;
            end else begin
               beat_cnt_nxt = 5'd0;
            end
            // the beat that brings the count to zero ends the rebased burst
            if (beat_cnt <= 5'd1) begin
               rebase_nxt = 1'b0;
            end else begin
               rebase_nxt = rebase;
            end
         end else begin
            beat_cnt_nxt = beat_cnt;
         end
      end else begin
         beat_cnt_nxt = beat_cnt;
      end
   end

   // Beat count and rebase registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= 5'd0;
         rebase   <= 1'b0;
      end else begin
         beat_cnt <= beat_cnt_nxt;
         rebase   <= rebase_nxt;
      end
   end

endmodule

// File: rtl/ahbmtx_l1_in_stg.sv
// ----------------------------------------------------------------------------
// ahbmtx_l1_in_stg
// Per-master input stage of the L1 AHB matrix. Passes the master address
// phase straight through when the arbiter grants it; otherwise captures it,
// stalls the master via hold_readyout and replays it once granted. Held SEQ
// beats are optionally rebased to NONSEQ/INCR so the slave sees a legal burst.
// Ports:
//   HCLK, HRESET        clock, asynchronous active-high reset
//   HSELS..HMASTLOCKS   master-side address phase
//   HREADYS             HREADY as seen by the master
//   grant               arbiter has selected this port
//   HREADYM             HREADY on the shared slave bus
//   req_port            request toward the output arbiter
//   HSELM..HMASTLOCKM   address phase presented to the arbiter mux
//   hold_readyout       low while a transfer is held (ANDed into HREADYOUT)
// ----------------------------------------------------------------------------
module ahbmtx_l1_in_stg
   import ahbmtx_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter bit REBASE_EN = 1'b1
)
(
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSELS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  logic [1:0]        HTRANSS,
   input  logic              HWRITES,
   input  logic [2:0]        HSIZES,
   input  logic [2:0]        HBURSTS,
   input  logic [3:0]        HPROTS,
   input  logic              HMASTLOCKS,
   input  logic              HREADYS,
   input  logic              grant,
   input  logic              HREADYM,
   output logic              req_port,
   output logic              HSELM,
   output logic [ADDR_W-1:0] HADDRM,
   output logic [1:0]        HTRANSM,
   output logic              HWRITEM,
   output logic [2:0]        HSIZEM,
   output logic [2:0]        HBURSTM,
   output logic [3:0]        HPROTM,
   output logic              HMASTLOCKM,
   output logic              hold_readyout
);

   in_stg_state_e     state;
   in_stg_state_e     state_nxt;

   logic              h_sel;
   logic [ADDR_W-1:0] h_addr;
   logic [1:0]        h_trans;
   logic              h_write;
   logic [2:0]        h_size;
   logic [2:0]        h_burst;
   logic [3:0]        h_prot;
   logic              h_lock;

   logic              valid;
   logic              capture;
   logic              pass_acc;
   logic              hold_acc;
   logic              rebase;

   // BUSY and IDLE have bit 1 clear, so they are never held
   assign valid    = HSELS & HTRANSS[1] & HREADYS;
   assign pass_acc = (state == ST_PASS) & valid & grant & HREADYM;
   assign capture  = (state == ST_PASS) & valid & ~(grant & HREADYM);
   assign hold_acc = (state == ST_HOLD) & grant & HREADYM;

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_PASS: begin
            if (capture) begin
               state_nxt = ST_HOLD;
            end else begin
               state_nxt = ST_PASS;
            end
         end
         ST_HOLD: begin
            if (hold_acc) begin
               state_nxt = ST_PASS;
            end else begin
               state_nxt = ST_HOLD;
            end
         end
         default: state_nxt = ST_PASS;
      endcase
   end

   // FSM state register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state <= ST_PASS;
      end else begin
         state <= state_nxt;
      end
   end

   // Held address-phase registers, loaded when a transfer cannot issue
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         h_sel   <= 1'b0;
         h_addr  <= '0;
         h_trans <= HTRANS_IDLE;
         h_write <= 1'b0;
         h_size  <= 3'b000;
         h_burst <= HBURST_SINGLE;
         h_prot  <= 4'b0000;
         h_lock  <= 1'b0;
      end else if (capture) begin
         h_sel   <= HSELS;
         h_addr  <= HADDRS;
         h_trans <= HTRANSS;
         h_write <= HWRITES;
         h_size  <= HSIZES;
         h_burst <= HBURSTS;
         h_prot  <= HPROTS;
         h_lock  <= HMASTLOCKS;
      end else begin
         h_sel   <= h_sel;
         h_addr  <= h_addr;
         h_trans <= h_trans;
         h_write <= h_write;
         h_size  <= h_size;
         h_burst <= h_burst;
         h_prot  <= h_prot;
         h_lock  <= h_lock;
      end
   end

   // The tracker always sees the master's original HTRANS/HBURST, not the
   // rebased values, so beat counting follows the real burst.
   ahbmtx_l1_in_stg_burst_trk u_trk (
      .clk        (HCLK),
      .rst        (HRESET),
      .acc        (pass_acc | hold_acc),
      .acc_trans  ((state == ST_HOLD) ? h_trans : HTRANSS),
      .acc_burst  ((state == ST_HOLD) ? h_burst : HBURSTS),
      .idle_seen  ((state == ST_PASS) & HSELS & HREADYS & (HTRANSS == HTRANS_IDLE)),
      .set_rebase (capture & REBASE_EN & (HTRANSS == HTRANS_SEQ)),
      .rebase     (rebase)
   );

   // Output mux: live inputs in PASS, held copy in HOLD, safe idle in reset
   always_comb begin
      HSELM         = HSELS;
      HADDRM        = HADDRS;
      HTRANSM       = HTRANSS;
      HWRITEM       = HWRITES;
      HSIZEM        = HSIZES;
      HBURSTM       = HBURSTS;
      HPROTM        = HPROTS;
      HMASTLOCKM    = HMASTLOCKS;
      req_port      = 1'b0;
      hold_readyout = 1'b1;
      case (state)
         ST_PASS: begin
            if (REBASE_EN && rebase && (HTRANSS == HTRANS_SEQ)) begin
               HBURSTM = HBURST_INCR;
            end else begin
               HBURSTM = HBURSTS;
            end
            // a locked master keeps the port even across IDLE beats
            req_port      = valid | (HSELS & HMASTLOCKS);
            hold_readyout = 1'b1;
         end
         ST_HOLD: begin
            HSELM      = h_sel;
            HADDRM     = h_addr;
            HWRITEM    = h_write;
            HSIZEM     = h_size;
            HPROTM     = h_prot;
            HMASTLOCKM = h_lock;
            if (REBASE_EN && (h_trans == HTRANS_SEQ)) begin
               HTRANSM = HTRANS_NONSEQ;
               HBURSTM = HBURST_INCR;
            end else begin
               HTRANSM = h_trans;
               HBURSTM = h_burst;
            end
            req_port      = 1'b1;
            hold_readyout = 1'b0;
         end
         default: begin
            HSELM         = 1'b0;
            HTRANSM       = HTRANS_IDLE;
            HMASTLOCKM    = 1'b0;
            req_port      = 1'b0;
            hold_readyout = 1'b1;
         end
      endcase
      // present a clean idle bus for as long as reset is asserted
      if (HRESET) begin
         HSELM         = 1'b0;
         HTRANSM       = HTRANS_IDLE;
         HMASTLOCKM    = 1'b0;
         req_port      = 1'b0;
         hold_readyout = 1'b1;
      end else begin
         hold_readyout = hold_readyout;
      end
   end

endmodule

// File: tb/tb_ahbmtx_l1_in_stg.sv
// ----------------------------------------------------------------------------
// tb_ahbmtx_l1_in_stg
// Directed testbench for ahbmtx_l1_in_stg. Two instances share the stimulus:
// u_dut with rebasing enabled and u_dut0 with rebasing disabled.
// ----------------------------------------------------------------------------
module tb_ahbmtx_l1_in_stg;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSELS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HMASTLOCKS;
   logic        HREADYS;
   logic        grant;
   logic        HREADYM;

   logic        req_port,   req_port_b;
   logic        HSELM,      HSELM_b;
   logic [31:0] HADDRM,     HADDRM_b;
   logic [1:0]  HTRANSM,    HTRANSM_b;
   logic        HWRITEM,    HWRITEM_b;
   logic [2:0]  HSIZEM,     HSIZEM_b;
   logic [2:0]  HBURSTM,    HBURSTM_b;
   logic [3:0]  HPROTM,     HPROTM_b;
   logic        HMASTLOCKM, HMASTLOCKM_b;
   logic        hold_readyout, hold_readyout_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 HCLK = ~HCLK;

   ahbmtx_l1_in_stg #(.ADDR_W(32), .REBASE_EN(1'b1)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
      .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
      .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
      .grant(grant), .HREADYM(HREADYM), .req_port(req_port), .HSELM(HSELM),
      .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
      .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
      .hold_readyout(hold_readyout)
   );

   ahbmtx_l1_in_stg #(.ADDR_W(32), .REBASE_EN(1'b0)) u_dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
      .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
      .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
      .grant(grant), .HREADYM(HREADYM), .req_port(req_port_b), .HSELM(HSELM_b),
      .HADDRM(HADDRM_b), .HTRANSM(HTRANSM_b), .HWRITEM(HWRITEM_b), .HSIZEM(HSIZEM_b),
      .HBURSTM(HBURSTM_b), .HPROTM(HPROTM_b), .HMASTLOCKM(HMASTLOCKM_b),
      .hold_readyout(hold_readyout_b)
   );

   task step;
      @(posedge HCLK);
      #1;
   endtask

   task drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
              input logic [2:0] burst, input logic lock, input logic rdy);
      HSELS      = sel;
      HADDRS     = addr;
      HTRANSS    = trans;
      HBURSTS    = burst;
      HMASTLOCKS = lock;
      HREADYS    = rdy;
      HWRITES    = 1'b0;
      HSIZES     = 3'b010;
      HPROTS     = 4'b0011;
   endtask

   task test_reset;
      #3;
      n_chk++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req_port); end
      n_chk++; if (hold_readyout !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", hold_readyout); end
      n_chk++; if (HTRANSM !== 2'b00) begin n_fail++; $display("FAIL reset_trans: got %b expected 00", HTRANSM); end
      n_chk++; if (HSELM !== 1'b0 || HMASTLOCKM !== 1'b0) begin n_fail++; $display("FAIL reset_sel_lock: got %b%b expected 00", HSELM, HMASTLOCKM); end
      step; step;
      HRESET = 1'b0;
   endtask

   task test_single;
      grant = 1'b1; HREADYM = 1'b1;
      drive(1'b1, 32'h2000_0000, 2'b10, 3'b000, 1'b0, 1'b1);
      #1;
      n_chk++; if (HTRANSM !== 2'b10 || HADDRM !== 32'h2000_0000) begin n_fail++; $display("FAIL single_pass: got %b %h expected 10 20000000", HTRANSM, HADDRM); end
      n_chk++; if (hold_readyout !== 1'b1 || req_port !== 1'b1) begin n_fail++; $display("FAIL single_ready_req: got %b%b expected 11", hold_readyout, req_port); end
      step;
      drive(1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
      #1;
      n_chk++; if (hold_readyout !== 1'b1 || HTRANSM !== 2'b00) begin n_fail++; $display("FAIL single_nohold: got %b %b expected 1 00", hold_readyout, HTRANSM); end
      step;
   endtask

   task test_hold;
      grant = 1'b0; HREADYM = 1'b1;
      drive(1'b1, 32'h0000_0040, 2'b10, 3'b000, 1'b0, 1'b1);
      #1;
      n_chk++; if (req_port !== 1'b1 || hold_readyout !== 1'b1) begin n_fail++; $display("FAIL hold_first: got %b%b expected 11", req_port, hold_readyout); end
      step;
      for (int i = 0; i < 3; i++) begin
         grant = (i == 2);
         drive(1'b1, 32'hDEAD_BEEF, 2'b11, 3'b111, 1'b1, 1'b0);
         #1;
         n_chk++; if (hold_readyout !== 1'b0) begin n_fail++; $display("FAIL hold_ready%0d: got %b expected 0", i, hold_readyout); end
         n_chk++; if (HADDRM !== 32'h0000_0040 || HTRANSM !== 2'b10 || HBURSTM !== 3'b000) begin n_fail++; $display("FAIL hold_addr%0d: got %h %b %b expected 00000040 10 000", i, HADDRM, HTRANSM, HBURSTM); end
         n_chk++; if (req_port !== 1'b1 || HMASTLOCKM !== 1'b0) begin n_fail++; $display("FAIL hold_req%0d: got %b%b expected 10", i, req_port, HMASTLOCKM); end
         step;
      end
      drive(1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
      #1;
      n_chk++; if (hold_readyout !== 1'b1 || HTRANSM !== 2'b00) begin n_fail++; $display("FAIL hold_exit: got %b %b expected 1 00", hold_readyout, HTRANSM); end
      step;
   endtask

   task test_rebase;
      grant = 1'b1; HREADYM = 1'b1;
      drive(1'b1, 32'h0000_0100, 2'b10, 3'b011, 1'b0, 1'b1);
      step;
      drive(1'b1, 32'h0000_0104, 2'b11, 3'b011, 1'b0, 1'b1);
      #1;
      n_chk++; if (u_dut.u_trk.beat_cnt !== 5'd3) begin n_fail++; $display("FAIL rb_cnt_load: got %0d expected 3", u_dut.u_trk.beat_cnt); end
      n_chk++; if (HTRANSM !== 2'b11 || HBURSTM !== 3'b011) begin n_fail++; $display("FAIL rb_beat2: got %b %b expected 11 011", HTRANSM, HBURSTM); end
      step;
      grant = 1'b0;
      drive(1'b1, 32'h0000_0108, 2'b11, 3'b011, 1'b0, 1'b1);
      step;
      for (int i = 0; i < 2; i++) begin
         grant = (i == 1);
         drive(1'b1, 32'h0000_0108, 2'b11, 3'b011, 1'b0, 1'b0);
         #1;
         n_chk++; if (HTRANSM !== 2'b10 || HBURSTM !== 3'b001 || HADDRM !== 32'h0000_0108) begin n_fail++; $display("FAIL rb_replay%0d: got %b %b %h expected 10 001 00000108", i, HTRANSM, HBURSTM, HADDRM); end
         n_chk++; if (HTRANSM_b !== 2'b11 || HBURSTM_b !== 3'b011 || HADDRM_b !== 32'h0000_0108) begin n_fail++; $display("FAIL rb_norebase%0d: got %b %b %h expected 11 011 00000108", i, HTRANSM_b, HBURSTM_b, HADDRM_b); end
         n_chk++; if (u_dut.u_trk.rebase !== 1'b1) begin n_fail++; $display("FAIL rb_flag%0d: got %b expected 1", i, u_dut.u_trk.rebase); end
         step;
      end
      drive(1'b1, 32'h0000_010C, 2'b11, 3'b011, 1'b0, 1'b1);
      #1;
      n_chk++; if (HTRANSM !== 2'b11 || HBURSTM !== 3'b001 || hold_readyout !== 1'b1) begin n_fail++; $display("FAIL rb_beat4: got %b %b %b expected 11 001 1", HTRANSM, HBURSTM, hold_readyout); end
      n_chk++; if (HBURSTM_b !== 3'b011) begin n_fail++; $display("FAIL rb_beat4_norebase: got %b expected 011", HBURSTM_b); end
      step;
      drive(1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
      #1;
      n_chk++; if (u_dut.u_trk.rebase !== 1'b0 || u_dut.u_trk.beat_cnt !== 5'd0) begin n_fail++; $display("FAIL rb_end: got %b %0d expected 0 0", u_dut.u_trk.rebase, u_dut.u_trk.beat_cnt); end
      step;
   endtask

   task test_locked;
      grant = 1'b1; HREADYM = 1'b1;
      drive(1'b1, 32'h0000_0200, 2'b10, 3'b000, 1'b1, 1'b1);
      #1;
      n_chk++; if (req_port !== 1'b1 || HMASTLOCKM !== 1'b1) begin n_fail++; $display("FAIL lock_ns1: got %b%b expected 11", req_port, HMASTLOCKM); end
      step;
      drive(1'b1, 32'h0000_0204, 2'b00, 3'b000, 1'b1, 1'b1);
      #1;
      n_chk++; if (req_port !== 1'b1 || HTRANSM !== 2'b00) begin n_fail++; $display("FAIL lock_idle: got %b %b expected 1 00", req_port, HTRANSM); end
      step;
      drive(1'b1, 32'h0000_0208, 2'b10, 3'b000, 1'b1, 1'b1);
      #1;
      n_chk++; if (req_port !== 1'b1) begin n_fail++; $display("FAIL lock_ns2: got %b expected 1", req_port); end
      step;
      drive(1'b1, 32'h0000_020C, 2'b00, 3'b000, 1'b0, 1'b1);
      #1;
      n_chk++; if (req_port !== 1'b0) begin n_fail++; $display("FAIL unlock_idle: got %b expected 0", req_port); end
      step;
   endtask

   task test_reset_in_hold;
      grant = 1'b0; HREADYM = 1'b1;
      drive(1'b1, 32'h0000_0080, 2'b10, 3'b011, 1'b1, 1'b1);
      step;
      drive(1'b1, 32'h0000_0080, 2'b10, 3'b011, 1'b1, 1'b0);
      #1;
      n_chk++; if (hold_readyout !== 1'b0 || HADDRM !== 32'h0000_0080) begin n_fail++; $display("FAIL rh_in_hold: got %b %h expected 0 00000080", hold_readyout, HADDRM); end
      #2;
      HRESET = 1'b1;
      #1;
      n_chk++; if (req_port !== 1'b0 || hold_readyout !== 1'b1) begin n_fail++; $display("FAIL rh_async: got %b%b expected 01", req_port, hold_readyout); end
      n_chk++; if (HTRANSM !== 2'b00 || HSELM !== 1'b0 || HMASTLOCKM !== 1'b0) begin n_fail++; $display("FAIL rh_idle: got %b %b%b expected 00 00", HTRANSM, HSELM, HMASTLOCKM); end
      step;
      HRESET = 1'b0;
      drive(1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
      step;
      n_chk++; if (hold_readyout !== 1'b1 || req_port !== 1'b0 || u_dut.u_trk.beat_cnt !== 5'd0) begin n_fail++; $display("FAIL rh_after: got %b%b %0d expected 10 0", hold_readyout, req_port, u_dut.u_trk.beat_cnt); end
   endtask

   initial begin
      HRESET  = 1'b1;
      grant   = 1'b0;
      HREADYM = 1'b1;
      drive(1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1);
      test_reset;
      test_single;
      test_hold;
      test_rebase;
      test_locked;
      test_reset_in_hold;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
